mem_port_arbiter: RTL

//  Shares one single-port, fixed-latency memory between the IF stage (instruction

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_ack_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAT_TOP    = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            owner_if_q, owner_if_d;
  logic            we_q, we_d;
  logic            if_ack_q, if_ack_d;
  logic            dm_ack_q, dm_ack_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            busy_q, busy_d;
  logic            grant_if_s, grant_dm_s;

  // Fetch wins only when alone or when data has starved it for STARVE_MAX grants.
  assign grant_if_s = if_req_i && (!dm_req_i || (starve_q == STARVE_TOP));
  assign grant_dm_s = dm_req_i && !grant_if_s;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    owner_if_d  = owner_if_q;
    we_d        = we_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    case (state_q)
      IDLE: begin
        if (grant_if_s || grant_dm_s) begin
          state_d     = ISSUE;
          owner_if_d  = grant_if_s;
          we_d        = grant_dm_s && dm_we_i;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dm_s && dm_we_i;
          mem_addr_d  = grant_if_s ? if_addr_i : dm_addr_i;
          mem_wdata_d = grant_dm_s ? dm_wdata_i : '0;
          if (grant_if_s || !if_req_i) begin
            starve_d = '0;
          end else if (starve_q != STARVE_TOP) begin
            starve_d = starve_q + SW'(1);
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_TOP;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = ACK;
          if_ack_d = owner_if_q;
          dm_ack_d = !owner_if_q;
          // Read data is valid only in this last wait cycle.
          if (!we_q && owner_if_q) begin
            if_rdata_d = mem_rdata_i;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata_i;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      owner_if_q  <= 1'b0;
      we_q        <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_if_q  <= owner_if_d;
      we_q        <= we_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;

endmodule
